gpu_regfile: RTL
================

GPU_REGFILE -- requirements
Module: gpu_regfile

Interface
REQ-001 SHALL have parameter NUM_FB, default 2, meaning pixel-buffer ring depth (legal 1..4).
REQ-002 SHALL have parameter ADDR_BITS, default 8, meaning s1 word-address width.
REQ-003 SHALL have parameter DEFAULT_FB, default DEFAULT_BUFFER, meaning reset value of every pixel-buffer address register.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have the s1 ports s1_address (input, ADDR_BITS), s1_read (input, 1), s1_write (input, 1), s1_writedata (input, 32), s1_readdata (output, 32), s1_readdatavalid (output, 1) and s1_waitrequest (output, 1), meaning the Avalon-MM host slave.
REQ-007 SHALL have port render_start, output, 1, meaning a one-cycle launch pulse to the controller.
REQ-008 SHALL have port render_done, input, 1, meaning a one-cycle completion pulse from the controller.
REQ-009 SHALL have port target_buffer, output, 32, meaning the address of the pixel buffer being rendered.
REQ-010 SHALL have ports voxel_buffer, voxel_count, palette_buffer and palette_length, each output, 32, meaning the scene registers.
REQ-011 SHALL have port cam_active, output, camera type, meaning the camera snapshot used by the current render.
REQ-012 SHALL have port irq, output, 1, meaning the level interrupt.

Function
REQ-013 SHALL use this register map: 0x00..0x03 FB[i] (i<NUM_FB; other offsets read 0 and ignore writes); 0x04 voxel_buffer; 0x05 voxel_count; 0x06 palette_buffer; 0x07 palette_length; 0x08 PERF; 0x0d IRQ_EN bit0; 0x0e STATUS (read-only); 0x0f CMD (write-only, reads 0); 0x10..0x1e camera pos, look0..look3 in x,y,z order.
REQ-014 SHALL lay out STATUS as bit0 busy, bit1 pending, bit2 done, bits[5:4] front index (last completed FB), bits[7:6] back index (FB being or next to be rendered).
REQ-015 SHALL return s1_readdata registered, with s1_readdatavalid high exactly 1 cycle after an accepted s1_read; reads never stall.
REQ-016 SHALL act on CMD writes as follows: bit0=1 requests a render; bit1=1 clears done; both bits may be set in the same write.
REQ-017 SHALL run a FSM with states IDLE, LAUNCH and BUSY.
REQ-018 SHALL move IDLE->LAUNCH on a render request.
REQ-019 SHALL, in LAUNCH (exactly 1 cycle), copy the camera host registers into cam_active, drive target_buffer=FB[back], pulse render_start, and then go to BUSY.
REQ-020 SHALL, in BUSY on render_done, set done, set front=back, set back=(back+1) mod NUM_FB, and go to LAUNCH if pending (clearing pending), else to IDLE.
REQ-021 SHALL set pending on a render request received in LAUNCH or BUSY; further requests while pending is set are dropped (queue depth 1).
REQ-022 SHALL ignore render_done outside BUSY.
REQ-023 SHALL make done win over a same-cycle CMD clear, so the interrupt is never lost.
REQ-024 SHALL drive irq = done & IRQ_EN, combinationally from registered state.
REQ-025 SHALL apply camera writes to host registers at any time without stalling; cam_active changes only in LAUNCH.
REQ-026 SHALL assert s1_waitrequest, in the same cycle, on a write to 0x04..0x07, or to FB[back], while the state is not IDLE; the write is held until IDLE, then committed.
REQ-027 SHALL keep the index arithmetic 2-bit and modulo NUM_FB; with NUM_FB=1, front=back=0 always.

Reset
REQ-028 SHALL, while reset=0 at a clock edge, set: FB[*]=DEFAULT_FB; scene registers, camera, cam_active, IRQ_EN and PERF to 0; state IDLE; pending=done=0; front=0; back=0; render_start=0; s1_readdatavalid=0; s1_readdata=0; irq=0.
REQ-029 SHALL let reset mid-render abandon the frame; a later render_done is ignored.

Configuration
REQ-030 SHALL, with GPU_REGFILE_PERF_EN defined, count clock cycles spent in LAUNCH+BUSY for each frame and latch the count into PERF on render_done, saturating at 0xFFFFFFFF.
REQ-031 SHALL, without GPU_REGFILE_PERF_EN, omit the counter; PERF reads 0.

Structure
REQ-032 SHALL take the camera and vec3 typedefs, DEFAULT_BUFFER, the register-offset localparams and the FSM state enum from the shared package.
REQ-033 SHALL place the FSM, pending, done, index and PERF logic in one sub-module, gpu_render_seq; decode, storage and readback stay in gpu_regfile.

Verification
REQ-034 SHALL cover: reset low 2 cycles -> STATUS reads 0x00000000 and FB0 reads DEFAULT_FB, with readdatavalid 1 cycle after the read.
REQ-035 SHALL cover: with NUM_FB=2, FB0=0x1000, FB1=0x2000, CMD=1, done pulse, CMD=1 -> target_buffer 0x1000 then 0x2000; STATUS[5:4] reads 1 after the second done.
REQ-036 SHALL cover: CMD=1 twice while BUSY -> one extra render_start only, exactly 1 cycle after the first render_done; STATUS bit1 returns to 0.
REQ-037 SHALL cover: write voxel_count=7 while BUSY -> waitrequest held until IDLE; camera pos.x=5 written while BUSY -> no stall, and cam_active.pos.x updates at the next LAUNCH.
REQ-038 SHALL cover: IRQ_EN=1, render_done in the same cycle as CMD=2 -> irq stays 1; a following CMD=2 -> irq 0.
REQ-039 SHALL cover: with GPU_REGFILE_PERF_EN, render_done 100 cycles after render_start -> PERF reads 101.

Source files
------------

// File: rtl/gpu_regfile_pkg.sv
// Shared types, register offsets and FSM states for the GPU register file.
package gpu_regfile_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned MAX_FB    = 4;
  localparam int unsigned CAM_WORDS = 15;
  localparam int unsigned CAM_SEL_W = 4;

  localparam logic [WORD_W-1:0] DEFAULT_BUFFER = 32'h0800_0000;

  localparam int unsigned REG_FB0       = 32'h00;
  localparam int unsigned REG_VOXEL_BUF = 32'h04;
  localparam int unsigned REG_VOXEL_CNT = 32'h05;
  localparam int unsigned REG_PAL_BUF   = 32'h06;
  localparam int unsigned REG_PAL_LEN   = 32'h07;
  localparam int unsigned REG_PERF      = 32'h08;
  localparam int unsigned REG_IRQ_EN    = 32'h0d;
  localparam int unsigned REG_STATUS    = 32'h0e;
  localparam int unsigned REG_CMD       = 32'h0f;
  localparam int unsigned REG_CAM0      = 32'h10;

  typedef struct packed {
    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] z;
  } vec3_t;

  typedef struct packed {
    vec3_t pos;
    vec3_t look0;
    vec3_t look1;
    vec3_t look2;
    vec3_t look3;
  } camera_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } seq_state_e;

endpackage

// File: rtl/gpu_render_seq.sv
// Render sequencer: launch FSM, one-deep request queue, done flag, buffer ring indices
// and the optional frame cycle counter (GPU_REGFILE_PERF_EN).
module gpu_render_seq
  import gpu_regfile_pkg::*;
#(
  parameter int unsigned NUM_FB = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              render_req,
  input  logic              done_clr,
  input  logic              render_done,
  output logic              busy,
  output logic              pending,
  output logic              done,
  output logic [IDX_W-1:0]  front,
  output logic [IDX_W-1:0]  back,
  output logic              launch_c,
  output logic [IDX_W-1:0]  launch_idx_c,
  output logic              render_start,
  output logic [WORD_W-1:0] perf
);

  seq_state_e       state_q, state_d;
  logic             pending_d, done_d;
  logic [IDX_W-1:0] front_d, back_d, back_inc_c;

  always_comb begin
    back_inc_c = back + 2'd1;
    if ({30'd0, back} + 32'd1 >= NUM_FB) back_inc_c = '0;
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending;
    done_d    = done;
    front_d   = front;
    back_d    = back;
    // Clear first so a same-cycle completion re-sets done and the interrupt survives.
    if (done_clr) done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (render_req) state_d = ST_LAUNCH;
      end
      ST_LAUNCH: begin
        state_d = ST_BUSY;
        if (render_req) pending_d = 1'b1;
      end
      ST_BUSY: begin
        if (render_done) begin
          done_d  = 1'b1;
          front_d = back;
          back_d  = back_inc_c;
          if (pending || render_req) begin
            state_d   = ST_LAUNCH;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (render_req) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    launch_c     = (state_d == ST_LAUNCH);
    launch_idx_c = back_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      busy         <= 1'b0;
      pending      <= 1'b0;
      done         <= 1'b0;
      front        <= '0;
      back         <= '0;
      render_start <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy         <= (state_d != ST_IDLE);
      pending      <= pending_d;
      done         <= done_d;
      front        <= front_d;
      back         <= back_d;
      render_start <= launch_c;
    end
  end

`ifdef GPU_REGFILE_PERF_EN
  logic [WORD_W-1:0] cnt_q, cnt_inc_c;

  assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + 32'd1;

  // cnt_q holds cycles already spent in the frame; the completing cycle is added on latch.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
      perf  <= '0;
    end else begin
      if (state_q == ST_BUSY && render_done) perf <= cnt_inc_c;
      if (launch_c) cnt_q <= '0;
      else if (state_q != ST_IDLE) cnt_q <= cnt_inc_c;
    end
  end
`else
  assign perf = '0;
`endif

endmodule

// File: rtl/gpu_regfile.sv
// Avalon-MM register file for the voxel GPU: decode, storage and readback.
// Frame cycle counter is built only when GPU_REGFILE_PERF_EN is defined.
module gpu_regfile
  import gpu_regfile_pkg::*;
#(
  parameter int unsigned NUM_FB     = 2,
  parameter int unsigned ADDR_BITS  = 8,
  parameter logic [31:0] DEFAULT_FB = DEFAULT_BUFFER
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [ADDR_BITS-1:0] s1_address,
  input  logic                 s1_read,
  input  logic                 s1_write,
  input  logic [31:0]          s1_writedata,
  output logic [31:0]          s1_readdata,
  output logic                 s1_readdatavalid,
  output logic                 s1_waitrequest,
  output logic                 render_start,
  input  logic                 render_done,
  output logic [31:0]          target_buffer,
  output logic [31:0]          voxel_buffer,
  output logic [31:0]          voxel_count,
  output logic [31:0]          palette_buffer,
  output logic [31:0]          palette_length,
  output camera_t              cam_active,
  output logic                 irq
);

  logic [WORD_W-1:0] fb_q  [MAX_FB];
  logic [WORD_W-1:0] cam_q [CAM_WORDS];
  logic              irq_en_q;

  logic                    busy, pending, done, launch_c;
  logic [IDX_W-1:0]        front, back, launch_idx_c;
  logic [WORD_W-1:0]       perf;
  logic [WORD_W-1:0]       status_c, rd_data_c;
  logic [CAM_WORDS*WORD_W-1:0] cam_flat_c;
  logic                    is_fb_c, fb_ok_c, is_scene_c, is_cam_c, wr_c;
  logic                    render_req_c, done_clr_c;
  logic [IDX_W-1:0]        fb_sel_c;
  logic [CAM_SEL_W-1:0]    cam_sel_c;

  assign is_fb_c    = (s1_address < ADDR_BITS'(REG_FB0 + MAX_FB));
  assign fb_sel_c   = s1_address[IDX_W-1:0];
  assign fb_ok_c    = ({30'd0, fb_sel_c} < NUM_FB);
  assign is_scene_c = (s1_address >= ADDR_BITS'(REG_VOXEL_BUF)) &&
                      (s1_address <= ADDR_BITS'(REG_PAL_LEN));
  assign is_cam_c   = (s1_address >= ADDR_BITS'(REG_CAM0)) &&
                      (s1_address < ADDR_BITS'(REG_CAM0 + CAM_WORDS));
  assign cam_sel_c  = CAM_SEL_W'(s1_address - ADDR_BITS'(REG_CAM0));

  // Scene registers and the buffer about to be rendered are frozen while a frame is in flight.
  assign s1_waitrequest = s1_write && busy &&
                          (is_scene_c || (is_fb_c && fb_sel_c == back));
  assign wr_c         = s1_write && !s1_waitrequest;
  assign render_req_c = wr_c && (s1_address == ADDR_BITS'(REG_CMD)) && s1_writedata[0];
  assign done_clr_c   = wr_c && (s1_address == ADDR_BITS'(REG_CMD)) && s1_writedata[1];

  assign status_c = {24'd0, back, front, 1'b0, done, pending, busy};
  assign irq      = done & irq_en_q;

  always_comb begin
    cam_flat_c = '0;
    for (int k = 0; k < CAM_WORDS; k++)
      cam_flat_c[(CAM_WORDS-1-k)*WORD_W +: WORD_W] = cam_q[k];
  end

  gpu_render_seq #(
    .NUM_FB(NUM_FB)
  ) u_seq (
    .clock        (clock),
    .reset        (reset),
    .render_req   (render_req_c),
    .done_clr     (done_clr_c),
    .render_done  (render_done),
    .busy         (busy),
    .pending      (pending),
    .done         (done),
    .front        (front),
    .back         (back),
    .launch_c     (launch_c),
    .launch_idx_c (launch_idx_c),
    .render_start (render_start),
    .perf         (perf)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < MAX_FB; i++) fb_q[i] <= DEFAULT_FB;
      for (int k = 0; k < CAM_WORDS; k++) cam_q[k] <= '0;
      voxel_buffer   <= '0;
      voxel_count    <= '0;
      palette_buffer <= '0;
      palette_length <= '0;
      irq_en_q       <= 1'b0;
      cam_active     <= '0;
      target_buffer  <= '0;
    end else begin
      if (wr_c) begin
        if (is_fb_c && fb_ok_c) fb_q[fb_sel_c] <= s1_writedata;
        if (s1_address == ADDR_BITS'(REG_VOXEL_BUF)) voxel_buffer   <= s1_writedata;
        if (s1_address == ADDR_BITS'(REG_VOXEL_CNT)) voxel_count    <= s1_writedata;
        if (s1_address == ADDR_BITS'(REG_PAL_BUF))   palette_buffer <= s1_writedata;
        if (s1_address == ADDR_BITS'(REG_PAL_LEN))   palette_length <= s1_writedata;
        if (s1_address == ADDR_BITS'(REG_IRQ_EN))    irq_en_q       <= s1_writedata[0];
        if (is_cam_c) cam_q[cam_sel_c] <= s1_writedata;
      end
      // Snapshot loads on entry to LAUNCH so it is valid alongside render_start.
      if (launch_c) begin
        cam_active    <= camera_t'(cam_flat_c);
        target_buffer <= fb_q[launch_idx_c];
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    if (is_fb_c)                                      rd_data_c = fb_ok_c ? fb_q[fb_sel_c] : '0;
    else if (s1_address == ADDR_BITS'(REG_VOXEL_BUF)) rd_data_c = voxel_buffer;
    else if (s1_address == ADDR_BITS'(REG_VOXEL_CNT)) rd_data_c = voxel_count;
    else if (s1_address == ADDR_BITS'(REG_PAL_BUF))   rd_data_c = palette_buffer;
    else if (s1_address == ADDR_BITS'(REG_PAL_LEN))   rd_data_c = palette_length;
    else if (s1_address == ADDR_BITS'(REG_PERF))      rd_data_c = perf;
    else if (s1_address == ADDR_BITS'(REG_IRQ_EN))    rd_data_c = {31'd0, irq_en_q};
    else if (s1_address == ADDR_BITS'(REG_STATUS))    rd_data_c = status_c;
    else if (is_cam_c)                                rd_data_c = cam_q[cam_sel_c];
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      s1_readdatavalid <= 1'b0;
      s1_readdata      <= '0;
    end else begin
      s1_readdatavalid <= s1_read;
      s1_readdata      <= s1_read ? rd_data_c : '0;
    end
  end

endmodule
